dmem_cache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache and controller.
- Sits between the pipelined datapath's memory-stage outputs (DM_addr, DM_writeData, DM_readEnable, DM_writeEnable) and a slow handshaked backing data memory.
- Returns DM_readData to the MEM/WB register and raises stall while a backing access is outstanding.
- The datapath must freeze all pipeline registers and hold its DM_* outputs stable while stall=1.

---
 rtl/dmem_cache_ctrl.sv | 142 ++++++++++++++
 tb/tb_dmem_cache_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting between the
// pipeline's memory stage and a slow handshaked backing memory.
module dmem_cache_ctrl #(
  parameter int N     = 64,
  parameter int LINES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_readEnable,
  input  logic         DM_writeEnable,
  output logic [N-1:0] DM_readData,
  output logic         stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ack
);

  localparam int IW = $clog2(LINES);
  localparam int TW = N - 3 - IW;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    WR_DONE
  } cacheStateT;

  cacheStateT state;
  cacheStateT nextState;

  logic [LINES-1:0] validBits;
  logic [TW-1:0]    tagMem  [LINES];
  logic [N-1:0]     dataMem [LINES];

  logic [IW-1:0] reqIndex;
  logic [TW-1:0] reqTag;
  logic [IW-1:0] fillIndex;
  logic [TW-1:0] fillTag;
  logic          reqHit;
  logic          fillHit;
  logic          ackSeen;
  logic          startRead;
  logic          startWrite;
  logic          unusedAddrBits;

  // Lookups use the live pipeline address; fills and write-through updates use
  // the registered backing address, which stays stable for the whole wait.
  assign reqIndex  = DM_addr[IW+2:3];
  assign reqTag    = DM_addr[N-1:IW+3];
  assign fillIndex = mem_addr[IW+2:3];
  assign fillTag   = mem_addr[N-1:IW+3];
  assign reqHit    = validBits[reqIndex] && (tagMem[reqIndex] == reqTag);
  assign fillHit   = validBits[fillIndex] && (tagMem[fillIndex] == fillTag);
  assign ackSeen   = mem_req && mem_ack;
  assign unusedAddrBits = ^{DM_addr[2:0], mem_addr[2:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState   = state;
    stall       = 1'b0;
    DM_readData = '0;
    startRead   = 1'b0;
    startWrite  = 1'b0;
    case (state)
      IDLE: begin
        // A store takes priority over a simultaneous load.
        if (DM_writeEnable) begin
          stall      = 1'b1;
          startWrite = 1'b1;
          nextState  = WR_THRU;
        end else if (DM_readEnable) begin
          if (reqHit) begin
            DM_readData = dataMem[reqIndex];
          end else begin
            stall     = 1'b1;
            startRead = 1'b1;
            nextState = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall = 1'b1;
        if (ackSeen) nextState = IDLE;
      end
      WR_THRU: begin
        stall = 1'b1;
        if (ackSeen) nextState = WR_DONE;
      end
      WR_DONE: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (startRead) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= {DM_addr[N-1:3], 3'b000};
    end else if (startWrite) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= {DM_addr[N-1:3], 3'b000};
      mem_wdata <= DM_writeData;
    end else if (ackSeen) begin
      mem_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                          validBits            <= '0;
    else if (state == RD_MISS && ackSeen) validBits[fillIndex] <= 1'b1;
  end

  // Reset suppresses the fill so an abandoned miss never leaves partial data.
  always_ff @(posedge clk) begin
    if (!reset && ackSeen) begin
      if (state == RD_MISS) begin
        tagMem[fillIndex]  <= fillTag;
        dataMem[fillIndex] <= mem_rdata;
      end else if (state == WR_THRU && fillHit) begin
        dataMem[fillIndex] <= mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Scoreboard bench for dmem_cache_ctrl: stimulus pushes expectations, a single
// monitor process pops and compares them as the DUT completes each access.
module tb_dmem_cache_ctrl;

  typedef struct {
    string       name;
    logic [63:0] data;
    int          stallCycles;
  } respT;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } memReqT;

  typedef enum int {P_STALL, P_MEMREQ, P_MEMWE, P_MEMADDR, P_MEMWDATA, P_RDATA, P_PENDING} probeSelT;

  typedef struct {
    string       name;
    probeSelT    sel;
    logic [63:0] exp;
  } probeT;

  logic        clk;
  logic        reset;
  logic [63:0] DM_addr;
  logic [63:0] DM_writeData;
  logic        DM_readEnable;
  logic        DM_writeEnable;
  logic [63:0] DM_readData;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        modelAck;
  logic        manualAck;

  int ackDelay;
  int total;
  int bad;

  respT   expQ[$];
  memReqT memQ[$];
  probeT  probeQ[$];

  assign mem_ack = modelAck | manualAck;

  dmem_cache_ctrl #(.N(64), .LINES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_readEnable  (DM_readEnable),
    .DM_writeEnable (DM_writeEnable),
    .DM_readData    (DM_readData),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  // Backing memory: acks in the ackDelay-th cycle that mem_req is high; ackDelay=0 never acks.
  initial begin : backingMemory
    logic [63:0] backMem [logic [63:0]];
    int reqCnt;
    backMem[64'h40]  = 64'hDEAD;
    backMem[64'hC0]  = 64'hBEEF;
    backMem[64'h200] = 64'h5555;
    backMem[64'h300] = 64'h7777;
    modelAck  = 1'b0;
    mem_rdata = '0;
    reqCnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      modelAck = 1'b0;
      if (mem_req) begin
        reqCnt++;
        if (ackDelay != 0 && reqCnt == ackDelay) begin
          modelAck = 1'b1;
          if (mem_we) backMem[mem_addr] = mem_wdata;
          else        mem_rdata = backMem.exists(mem_addr) ? backMem[mem_addr] : 64'h0;
        end
      end else begin
        reqCnt = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] sampleSig(input probeSelT sel);
    case (sel)
      P_STALL:    return {63'd0, stall};
      P_MEMREQ:   return {63'd0, mem_req};
      P_MEMWE:    return {63'd0, mem_we};
      P_MEMADDR:  return mem_addr;
      P_MEMWDATA: return mem_wdata;
      P_RDATA:    return DM_readData;
      default:    return 64'(expQ.size() + memQ.size());
    endcase
  endfunction

  // Monitor: owns every comparison and the pass/fail counters.
  initial begin : monitor
    int   stallCount;
    logic prevMemReq;
    respT r;
    memReqT m;
    probeT p;
    stallCount = 0;
    prevMemReq = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stallCount = 0;
      end else begin
        if (mem_req && !prevMemReq) begin
          if (memQ.size() == 0) begin
            checkOutput("unexpectedMemReq", 64'd0, 64'd1);
          end else begin
            m = memQ.pop_front();
            checkOutput("memWe", {63'd0, mem_we}, {63'd0, m.we});
            checkOutput("memAddr", mem_addr, m.addr);
            if (m.we) checkOutput("memWdata", mem_wdata, m.wdata);
          end
        end
        if (DM_readEnable || DM_writeEnable) begin
          if (stall) begin
            stallCount++;
          end else if (expQ.size() == 0) begin
            checkOutput("unexpectedCompletion", 64'd0, 64'd1);
            stallCount = 0;
          end else begin
            r = expQ.pop_front();
            checkOutput({r.name, ".data"}, DM_readData, r.data);
            checkOutput({r.name, ".stallCycles"}, 64'(stallCount), 64'(r.stallCycles));
            stallCount = 0;
          end
        end
      end
      while (probeQ.size() > 0) begin
        p = probeQ.pop_front();
        checkOutput(p.name, sampleSig(p.sel), p.exp);
      end
      prevMemReq = mem_req;
    end
  end

  task automatic probe(input string name, input probeSelT sel, input logic [63:0] exp);
    probeT p;
    p.name = name;
    p.sel  = sel;
    p.exp  = exp;
    probeQ.push_back(p);
  endtask

  task automatic applyStimulus(input string name, input bit rd, input bit wr,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] expData, input int expStall);
    respT r;
    memReqT m;
    bit done;
    r.name        = name;
    r.data        = expData;
    r.stallCycles = expStall;
    expQ.push_back(r);
    if (expStall > 0) begin
      m.we    = wr;
      m.addr  = addr & ~64'h7;
      m.wdata = wr ? wdata : 64'h0;
      memQ.push_back(m);
    end
    @(posedge clk);
    #2;
    DM_addr        = addr;
    DM_writeData   = wdata;
    DM_readEnable  = rd;
    DM_writeEnable = wr;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) probe({name, ".timeout"}, P_STALL, 64'd0);
    @(posedge clk);
    #2;
    DM_readEnable  = 1'b0;
    DM_writeEnable = 1'b0;
  endtask

  initial begin : stimulus
    total          = 0;
    bad            = 0;
    ackDelay       = 3;
    manualAck      = 1'b0;
    reset          = 1'b1;
    DM_addr        = '0;
    DM_writeData   = '0;
    DM_readEnable  = 1'b0;
    DM_writeEnable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    probe("resetStall", P_STALL, 64'd0);
    probe("resetMemReq", P_MEMREQ, 64'd0);
    probe("resetMemWe", P_MEMWE, 64'd0);
    probe("resetMemAddr", P_MEMADDR, 64'd0);
    probe("resetMemWdata", P_MEMWDATA, 64'd0);
    probe("resetReadData", P_RDATA, 64'd0);

    applyStimulus("coldRead40", 1, 0, 64'h40, 64'h0, 64'hDEAD, 4);
    applyStimulus("hit40",      1, 0, 64'h40, 64'h0, 64'hDEAD, 0);
    applyStimulus("hit45",      1, 0, 64'h45, 64'h0, 64'hDEAD, 0);
    applyStimulus("evictC0",    1, 0, 64'hC0, 64'h0, 64'hBEEF, 4);
    applyStimulus("reMiss40",   1, 0, 64'h40, 64'h0, 64'hDEAD, 4);

    ackDelay = 2;
    applyStimulus("wtStore40",  0, 1, 64'h40, 64'h1234, 64'h0, 3);
    applyStimulus("wtHit40",    1, 0, 64'h40, 64'h0, 64'h1234, 0);
    applyStimulus("nwaStore200", 0, 1, 64'h200, 64'h9999, 64'h0, 3);
    ackDelay = 3;
    applyStimulus("nwaLoad200", 1, 0, 64'h200, 64'h0, 64'h9999, 4);
    ackDelay = 2;
    applyStimulus("missStore600", 0, 1, 64'h600, 64'hAAAA, 64'h0, 3);
    applyStimulus("hit200",     1, 0, 64'h200, 64'h0, 64'h9999, 0);
    applyStimulus("bothStore40", 1, 1, 64'h40, 64'h4321, 64'h0, 3);
    applyStimulus("hit40New",   1, 0, 64'h40, 64'h0, 64'h4321, 0);

    // Abandon a read miss with reset, then ack late; the ack must be ignored.
    ackDelay = 0;
    begin
      memReqT m;
      m.we    = 1'b0;
      m.addr  = 64'h300;
      m.wdata = 64'h0;
      memQ.push_back(m);
    end
    @(posedge clk);
    #2;
    DM_addr       = 64'h300;
    DM_readEnable = 1'b1;
    probe("rstMissStall", P_STALL, 64'd1);
    @(posedge clk);
    #2;
    probe("rstWaitMemReq", P_MEMREQ, 64'd1);
    @(posedge clk);
    #2;
    reset         = 1'b1;
    DM_readEnable = 1'b0;
    @(posedge clk);
    #2;
    reset     = 1'b0;
    manualAck = 1'b1;
    probe("rstMemReqCleared", P_MEMREQ, 64'd0);
    probe("rstStallCleared", P_STALL, 64'd0);
    @(posedge clk);
    #2;
    manualAck = 1'b0;
    probe("lateAckIgnoredReq", P_MEMREQ, 64'd0);
    probe("lateAckIgnoredStall", P_STALL, 64'd0);
    ackDelay = 3;
    applyStimulus("postResetMiss40", 1, 0, 64'h40, 64'h0, 64'h4321, 4);

    probe("scoreboardDrained", P_PENDING, 64'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
